// File: rtl/mfhwt_output_drain.sv
// Purpose: drains the four Buffer2 row FIFOs in row/group order onto one valid/ready word stream.
// Latency: FIFO word reaches oData two cycles after its rdreq; 1 word/cycle sustained with iReady high.
// Backpressure: credit-limited reads keep at most 2 words outstanding; head word and tags hold while stalled.
module mfhwt_output_drain #(
    parameter int DATA_W  = 16,
    parameter int ROW_LEN = 32,
    parameter int GROUPS  = 8
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic                  iStart,
    input  logic                  iFlush,
    input  logic [3:0]            iFull_Buffer2,
    input  logic [3:0]            iEmpty_Buffer2,
    input  logic [4*DATA_W-1:0]   iData_Buffer2,
    output logic [3:0]            oRdreq_Buffer2,
    output logic [DATA_W-1:0]     oData,
    output logic                  oValid,
    input  logic                  iReady,
    output logic                  oSof,
    output logic                  oEol,
    output logic                  oFrame_done,
    output logic                  oBusy
);

    localparam int WCNT_W = $clog2(ROW_LEN + 1);
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int ENT_W  = DATA_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [1:0]          sel;
    logic [WCNT_W-1:0]   word_cnt;
    logic [GRP_W-1:0]    grp_cnt;
    logic                sof_pend;
    logic                inflight, inflight_sof, inflight_eol;
    logic [1:0]          inflight_sel;
    logic [ENT_W-1:0]    q0, q1;
    logic [1:0]          occ;
    logic                pop, push, rd_en, credit_ok, row_last, grp_last;
    logic [DATA_W-1:0]   rd_word;
    logic [ENT_W-1:0]    new_ent;

    assign pop       = oValid & iReady;
    assign push      = inflight;
    // A read may issue only if its word will still fit once everything already committed lands.
    assign credit_ok = (3'(occ) + 3'(inflight)) < (3'd2 + 3'(pop));
    assign row_last  = (word_cnt == WCNT_W'(ROW_LEN - 1));
    assign grp_last  = (grp_cnt == GRP_W'(GROUPS - 1));
    assign rd_en     = (state == S_DRAIN) && !iEmpty_Buffer2[sel] &&
                       (word_cnt < WCNT_W'(ROW_LEN)) && credit_ok;

    assign rd_word = iData_Buffer2[int'(inflight_sel) * DATA_W +: DATA_W];
    assign new_ent = {inflight_sof, inflight_eol, rd_word};

    assign oRdreq_Buffer2 = rd_en ? (4'b0001 << sel) : 4'b0000;
    assign oValid = (occ != 2'd0);
    assign oData  = q0[DATA_W-1:0];
    assign oEol   = oValid & q0[DATA_W];
    assign oSof   = oValid & q0[DATA_W+1];
    assign oBusy  = (state != S_IDLE);

    // State register.
    always_ff @(posedge iClk) begin
        if (!iReset_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic and the frame-done pulse, which fires while still in DONE.
    always_comb begin
        state_nxt   = state;
        oFrame_done = 1'b0;
        case (state)
            S_IDLE:  if (iStart) state_nxt = S_WAIT;
            S_WAIT:  if ((&iFull_Buffer2) || iFlush) state_nxt = S_DRAIN;
            S_DRAIN: if (rd_en && row_last && (sel == 2'd3))
                         state_nxt = grp_last ? S_DONE : S_WAIT;
            S_DONE:  if ((occ == 2'd0) && !inflight) begin
                         oFrame_done = 1'b1;
                         state_nxt   = S_IDLE;
                     end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Row/FIFO/group position tracking; only an issued read moves the counters.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            sel      <= 2'd0;
            word_cnt <= '0;
            grp_cnt  <= '0;
            sof_pend <= 1'b0;
        end else begin
            if (state == S_IDLE && iStart) begin
                sel      <= 2'd0;
                word_cnt <= '0;
                grp_cnt  <= '0;
                sof_pend <= 1'b1;
            end
            if (state == S_WAIT && state_nxt == S_DRAIN)
                sel <= 2'd0;
            if (rd_en) begin
                sof_pend <= 1'b0;
                if (row_last) begin
                    word_cnt <= '0;
                    sel      <= sel + 2'd1;
                    if (sel == 2'd3)
                        grp_cnt <= grp_last ? '0 : grp_cnt + GRP_W'(1);
                end else begin
                    word_cnt <= word_cnt + WCNT_W'(1);
                end
            end
        end
    end

    // Remember which FIFO was read and the tags that belong to that word.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            inflight     <= 1'b0;
            inflight_sel <= 2'd0;
            inflight_sof <= 1'b0;
            inflight_eol <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                inflight_sel <= sel;
                inflight_sof <= sof_pend;
                inflight_eol <= row_last;
            end
        end
    end

    // Two-entry output queue; q0 is always the head.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            q0  <= '0;
            q1  <= '0;
            occ <= 2'd0;
        end else begin
            if (push && pop) begin
                if (occ == 2'd1) begin
                    q0 <= new_ent;
                end else begin
                    q0 <= q1;
                    q1 <= new_ent;
                end
            end else if (pop) begin
                q0 <= q1;
            end else if (push) begin
                if (occ == 2'd0) q0 <= new_ent;
                else             q1 <= new_ent;
            end
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_mfhwt_output_drain.sv
// Bench for mfhwt_output_drain: FIFO models feed random words; a monitor scores the stream.
// Expected words come from what the bench wrote into each FIFO, ordered by row position.
// Ready patterns: always-on, 1-0-0-1, always-off, random.
module tb_mfhwt_output_drain;

    localparam int DW = 16;
    localparam int RL = 4;
    localparam int GR = 2;
    localparam int FW = RL * 4 * GR;

    logic            clk = 1'b0;
    logic            rst_n, start, flush, ready;
    logic [3:0]      full, empty, rdreq;
    logic [4*DW-1:0] fdata;
    logic [DW-1:0]   odata;
    logic            ovalid, osof, oeol, odone, obusy;

    always #5 clk = ~clk;

    mfhwt_output_drain #(.DATA_W(DW), .ROW_LEN(RL), .GROUPS(GR)) dut (
        .iClk(clk), .iReset_n(rst_n), .iStart(start), .iFlush(flush),
        .iFull_Buffer2(full), .iEmpty_Buffer2(empty), .iData_Buffer2(fdata),
        .oRdreq_Buffer2(rdreq), .oData(odata), .oValid(ovalid), .iReady(ready),
        .oSof(osof), .oEol(oeol), .oFrame_done(odone), .oBusy(obusy)
    );

    // ---------------- Buffer2 FIFO models (non-show-ahead) ----------------
    logic [DW-1:0] mem [4][512];
    int            wr_ptr [4] = '{default: 0};
    int            rd_ptr [4] = '{default: 0};
    logic [DW-1:0] dout   [4] = '{default: '0};

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (rdreq[k] && rd_ptr[k] != wr_ptr[k]) begin
                dout[k]   <= mem[k][rd_ptr[k]];
                rd_ptr[k] <= rd_ptr[k] + 1;
            end
    end

    for (genvar k = 0; k < 4; k++) begin : g_fifo
        assign empty[k] = (rd_ptr[k] == wr_ptr[k]);
        assign full[k]  = ((wr_ptr[k] - rd_ptr[k]) >= RL);
        assign fdata[k*DW +: DW] = dout[k];
    end

    // ---------------- monitor / scoreboard ----------------
    int errs = 0, checks = 0;
    int pos = 0, out_cnt = 0, done_cnt = 0, cyc = 0, last_xfer = 0;
    int exp_idx [4] = '{default: 0};
    bit chk_gap = 0;
    string  req_nm = "";
    longint req_act = 0, req_exp = 0;
    int     req_seq = 0;

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    initial begin : monitor
        bit pend = 1'b1;
        bit hold = 1'b0;
        logic [DW+1:0] held = '0;
        int done_seq = 0;
        int k;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend = 1'b1;
            end else begin
                if (pend) begin
                    pend = 1'b0; pos = 0; out_cnt = 0; hold = 1'b0;
                    for (int i = 0; i < 4; i++) exp_idx[i] = rd_ptr[i];
                end
                if (hold) begin
                    chk("hold_valid", ovalid, 1);
                    chk("hold_word", {osof, oeol, odata}, held);
                end
                if (rdreq != 4'd0) begin
                    chk("rdreq_onehot", $countones(rdreq), 1);
                    chk("rdreq_nonempty", |(rdreq & empty), 0);
                end
                out_cnt += ((rdreq != 4'd0) ? 1 : 0) - ((ovalid && ready) ? 1 : 0);
                if (rdreq != 4'd0) chk("outstanding_le2", (out_cnt <= 2) ? 1 : 0, 1);
                if (ovalid && ready) begin
                    k = (pos / RL) % 4;
                    chk("data", odata, mem[k][exp_idx[k]]);
                    exp_idx[k]++;
                    chk("sof", osof, (pos == 0) ? 1 : 0);
                    chk("eol", oeol, (pos % RL == RL - 1) ? 1 : 0);
                    if (chk_gap && (pos % (4 * RL)) != 0) chk("gap", cyc - last_xfer, 1);
                    last_xfer = cyc;
                    pos++;
                end
                hold = ovalid && !ready;
                held = {osof, oeol, odata};
                if (odone) begin
                    chk("done_pos", pos, FW);
                    chk("done_latency", cyc - last_xfer, 1);
                    done_cnt++;
                    pos = 0;
                end
                if (req_seq != done_seq) begin
                    chk(req_nm, req_act, req_exp);
                    done_seq = req_seq;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int rmode = 0, phase = 0;
    logic [3:0] pat = 4'b1001;

    task automatic tick();
        logic [3:0] p;
        @(posedge clk); #1;
        phase++;
        p = pat;
        case (rmode)
            0: ready = 1'b1;
            1: ready = p[phase % 4];
            2: ready = 1'b0;
            default: ready = 1'($urandom % 2);
        endcase
    endtask

    task automatic post(string nm, longint act, longint exp);
        req_nm = nm; req_act = act; req_exp = exp; req_seq++;
        tick();
    endtask

    task automatic fill(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            mem[k][wr_ptr[k]] = DW'($urandom);
            wr_ptr[k]++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit poke);
        int prev = done_cnt;
        int n = 0;
        while (done_cnt == prev && n < budget) begin
            if (poke) start = obusy && (odone || (n % 7 == 3));
            tick(); n++;
        end
        start = 1'b0;
        post("frame_done_wait", done_cnt - prev, 1);
        if (poke) post("start_in_done_ignored", obusy, 0);
    endtask

    task automatic fill_all(input int n);
        for (int k = 0; k < 4; k++) fill(k, n);
    endtask

    initial begin
        int n, rds, dc;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; ready = 1'b1;
        repeat (3) tick();
        post("reset_outputs", {ovalid, osof, oeol, odone, obusy, rdreq, odata}, 0);
        rst_n = 1'b1;
        tick();

        // 1: full FIFOs, always ready, back-to-back within a group
        rmode = 0; chk_gap = 1;
        fill_all(2 * RL);
        pulse_start();
        wait_done(1000, 0);
        chk_gap = 0;

        // 2: ready 1,0,0,1
        rmode = 1;
        fill_all(2 * RL);
        pulse_start();
        wait_done(1000, 0);

        // 3: FIFO 2 runs dry after two words, refilled 10 cycles later
        rmode = 0; flush = 1'b1;
        fill(0, 2 * RL); fill(1, 2 * RL); fill(3, 2 * RL); fill(2, 2);
        pulse_start();
        n = 0;
        while (rd_ptr[2] - (wr_ptr[2] - 2) < 2 && n < 200) begin tick(); n++; end
        repeat (10) tick();
        post("pause_after_word_2_1", pos, 2 * RL + 2);
        fill(2, 2 * RL - 2);
        wait_done(1000, 0);
        flush = 1'b0;

        // 4: second group missing FIFO 3 until flush plus late fill
        dc = done_cnt;
        fill_all(RL); fill(0, RL); fill(1, RL); fill(2, RL);
        pulse_start();
        n = 0;
        while (pos < 4 * RL && n < 200) begin tick(); n++; end
        rds = rd_ptr[0] + rd_ptr[1] + rd_ptr[2] + rd_ptr[3];
        repeat (20) tick();
        post("wait_no_reads", (rd_ptr[0] + rd_ptr[1] + rd_ptr[2] + rd_ptr[3]) - rds, 0);
        post("wait_busy", obusy, 1);
        flush = 1'b1;
        repeat (5) tick();
        fill(3, RL);
        wait_done(1000, 0);
        flush = 1'b0;
        repeat (10) tick();
        post("single_done", done_cnt - dc, 1);

        // 5: reset mid-row with two words outstanding
        rmode = 2;
        fill_all(2 * RL);
        pulse_start();
        repeat (8) tick();
        post("pre_reset_outstanding", out_cnt, 2);
        rst_n = 1'b0;
        tick();
        post("midframe_reset_outputs", {ovalid, osof, oeol, odone, obusy, rdreq, odata}, 0);
        rst_n = 1'b1;
        rmode = 0;
        fill(0, 2);
        tick();
        pulse_start();
        wait_done(1000, 0);

        // 6: random ready, iStart poked while busy and in DONE
        rmode = 3;
        fill_all(2 * RL);
        pulse_start();
        wait_done(2000, 1);

        rmode = 0;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
